// File: rtl/tri_feeder_if.sv
// tri_feeder_if: upstream triangle request channel.
//   tri_valid : request present (master -> slave)
//   tri_data  : {x1,y1,x2,y2,x3,y3}, 3 bits each, x1 in [17:15] (master -> slave)
//   tri_ready : slave can accept a request (slave -> master)
interface tri_feeder_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [17:0] tri_data;

  modport master (
    output tri_valid,
    output tri_data,
    input  tri_ready
  );

  modport slave (
    input  tri_valid,
    input  tri_data,
    output tri_ready
  );
endinterface

// File: rtl/tri_feeder.sv
// tri_feeder: accepts one triangle at a time, streams its three vertices to a
// coordinate engine, then counts and sums the points the engine returns.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   tri_if (slave)    : request channel (tri_valid / tri_ready / tri_data)
//   nt, xi, yi        : new-triangle strobe and vertex coordinates to the engine
//   busy, po, xo, yo  : engine busy, point-valid and point coordinates
//   done              : one-cycle result strobe
//   pt_count          : points received (saturates at 64)
//   pt_xsum, pt_ysum  : coordinate sums (saturate at 511)
//   err               : watchdog abort, valid with done
//
// Build option: define TRI_FEEDER_WATCHDOG_EN to add an 8-bit watchdog that
// aborts WAIT/COLLECT after 255 cycles with err=1. Without it err is 0 and the
// feeder waits on the engine indefinitely.
module tri_feeder (
  input  logic        clk,
  input  logic        reset,
  tri_feeder_if.slave tri_if,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic        done,
  output logic [6:0]  pt_count,
  output logic [8:0]  pt_xsum,
  output logic [8:0]  pt_ysum,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StCollect,
    StReport
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_k;
  logic [17:0] r_data;
  logic [6:0]  r_count;
  logic [8:0]  r_xsum;
  logic [8:0]  r_ysum;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;
  logic [9:0]  w_xsum_add;
  logic [9:0]  w_ysum_add;

  assign w_accept  = (r_state == StIdle) && tri_if.tri_valid;
  // Points are only meaningful while a triangle is in flight.
  assign w_capture = po && ((r_state == StSend) || (r_state == StWait) ||
                            (r_state == StCollect));

  assign w_xsum_add = {1'b0, r_xsum} + {7'd0, xo};
  assign w_ysum_add = {1'b0, r_ysum} + {7'd0, yo};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (tri_if.tri_valid) w_state_next = StSend;
      StSend:    if (r_k == 2'd2) w_state_next = StWait;
      StWait: begin
        if (w_timeout)  w_state_next = StReport;
        else if (busy)  w_state_next = StCollect;
      end
      StCollect: begin
        if (w_timeout || !busy) w_state_next = StReport;
      end
      StReport:  w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_k     <= 2'd0;
      r_data  <= 18'd0;
      r_count <= 7'd0;
      r_xsum  <= 9'd0;
      r_ysum  <= 9'd0;
    end else begin
      r_state <= w_state_next;
      r_k     <= ((r_state == StSend) && (w_state_next == StSend)) ? r_k + 2'd1 : 2'd0;
      if (w_accept) begin
        r_data  <= tri_if.tri_data;
        r_count <= 7'd0;
        r_xsum  <= 9'd0;
        r_ysum  <= 9'd0;
      end else if (w_capture) begin
        r_count <= (r_count == 7'd64) ? 7'd64 : r_count + 7'd1;
        r_xsum  <= w_xsum_add[9] ? 9'h1FF : w_xsum_add[8:0];
        r_ysum  <= w_ysum_add[9] ? 9'h1FF : w_ysum_add[8:0];
      end
    end
  end

`ifdef TRI_FEEDER_WATCHDOG_EN
  logic [7:0] r_wd;
  logic       r_err;

  assign w_timeout = ((r_state == StWait) || (r_state == StCollect)) && (r_wd == 8'hFF);

  // Cleared on every state change so WAIT and COLLECT each get a fresh budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd  <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (w_state_next != r_state) begin
        r_wd <= 8'd0;
      end else if ((r_state == StWait) || (r_state == StCollect)) begin
        r_wd <= r_wd + 8'd1;
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    xi = 3'd0;
    yi = 3'd0;
    if (r_state == StSend) begin
      unique case (r_k)
        2'd0: begin xi = r_data[17:15]; yi = r_data[14:12]; end
        2'd1: begin xi = r_data[11:9];  yi = r_data[8:6];   end
        2'd2: begin xi = r_data[5:3];   yi = r_data[2:0];   end
        default: begin xi = 3'd0; yi = 3'd0; end
      endcase
    end
  end

  assign tri_if.tri_ready = (r_state == StIdle);
  assign nt               = (r_state == StSend) && (r_k == 2'd0);
  assign done             = (r_state == StReport);
  assign pt_count         = r_count;
  assign pt_xsum          = r_xsum;
  assign pt_ysum          = r_ysum;

endmodule

// File: tb/tb_tri_feeder.sv
// Bench for tri_feeder: table of triangle/engine vectors plus hand-written
// sequences for reset, idle points, held valid and the engine watchdog.
module tb_tri_feeder;

  logic       clk;
  logic       reset;
  logic       nt;
  logic [2:0] xi;
  logic [2:0] yi;
  logic       busy;
  logic       po;
  logic [2:0] xo;
  logic [2:0] yo;
  logic       done;
  logic [6:0] pt_count;
  logic [8:0] pt_xsum;
  logic [8:0] pt_ysum;
  logic       err;

  tri_feeder_if u_if ();

  tri_feeder u_dut (
    .clk      (clk),
    .reset    (reset),
    .tri_if   (u_if),
    .nt       (nt),
    .xi       (xi),
    .yi       (yi),
    .busy     (busy),
    .po       (po),
    .xo       (xo),
    .yo       (yo),
    .done     (done),
    .pt_count (pt_count),
    .pt_xsum  (pt_xsum),
    .pt_ysum  (pt_ysum),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0]      data;
    int               npts;
    int               busy_len;
    bit               fall_po;
    logic [2:0]       fx;
    logic [2:0]       fy;
    logic [7:0][2:0]  px;
    logic [7:0][2:0]  py;
  } vec_t;

  typedef struct {
    int c;
    int x;
    int y;
    int e;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_done   = 0;
  exp_t exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_count", pt_count, e.c);
        chk("sb_xsum", pt_xsum, e.x);
        chk("sb_ysum", pt_ysum, e.y);
        chk("sb_err", err, e.e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Called before a posedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_tri(input vec_t v, input bit hold);
    int          c;
    int          xs;
    int          ys;
    exp_t        e;
    logic [17:0] d;
    c  = 0;
    xs = 0;
    ys = 0;
    d  = v.data;
    for (int j = 0; j < v.npts; j++) begin
      c++;
      xs += int'(v.px[j % 8]);
      ys += int'(v.py[j % 8]);
    end
    if (v.fall_po) begin
      c++;
      xs += int'(v.fx);
      ys += int'(v.fy);
    end
    if (c > 64)   c  = 64;
    if (xs > 511) xs = 511;
    if (ys > 511) ys = 511;
    e.c = c; e.x = xs; e.y = ys; e.e = 0;
    exp_q.push_back(e);
    n_pushed++;

    u_if.tri_valid = 1'b1;
    u_if.tri_data  = v.data;
    step();
    if (!hold) u_if.tri_valid = 1'b0;
    u_if.tri_data = ~v.data;  // latched copy must be used from here on
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("send_nt", nt, (k == 0));
      chk("send_xi", xi, d[17-6*k -: 3]);
      chk("send_yi", yi, d[14-6*k -: 3]);
      chk("send_ready", u_if.tri_ready, 0);
      step();
    end
    for (int j = 0; j < v.busy_len; j++) begin
      busy = 1'b1;
      po   = (j < v.npts);
      xo   = v.px[j % 8];
      yo   = v.py[j % 8];
      @(negedge clk);
      if (j == 0) begin
        chk("wait_nt", nt, 0);
        chk("wait_xi", xi, 0);
        chk("wait_yi", yi, 0);
      end
      chk("busy_ready", u_if.tri_ready, 0);
      chk("busy_done", done, 0);
      step();
    end
    busy = 1'b0;
    po   = v.fall_po;
    xo   = v.fx;
    yo   = v.fy;
    @(negedge clk);
    chk("fall_done", done, 0);
    step();
    po = 1'b1;  // ignored in REPORT
    xo = 3'd7;
    yo = 3'd7;
    @(negedge clk);
    chk("report_done", done, 1);
    chk("report_ready", u_if.tri_ready, 0);
    step();
    po = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_ready", u_if.tri_ready, 1);
    chk("hold_count", pt_count, c);
    chk("hold_xsum", pt_xsum, xs);
    chk("hold_ysum", pt_ysum, ys);
    chk("hold_err", err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    int cyc;
    int got;
    int held;

    vecs[0].data = 18'b000_000_000_010_010_010;
    vecs[0].npts = 6; vecs[0].busy_len = 6; vecs[0].fall_po = 1'b0;
    vecs[0].fx = 3'd0; vecs[0].fy = 3'd0;
    vecs[0].px = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0};
    vecs[0].py = {3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};

    vecs[1].data = 18'b101_011_101_011_101_011;  // degenerate: one point thrice
    vecs[1].npts = 3; vecs[1].busy_len = 5; vecs[1].fall_po = 1'b1;
    vecs[1].fx = 3'd7; vecs[1].fy = 3'd1;
    vecs[1].px = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd3, 3'd1};
    vecs[1].py = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd4, 3'd2};

    vecs[2].data = 18'b111_111_000_000_011_100;
    vecs[2].npts = 0; vecs[2].busy_len = 2; vecs[2].fall_po = 1'b0;
    vecs[2].fx = 3'd0; vecs[2].fy = 3'd0;
    vecs[2].px = '0; vecs[2].py = '0;

    vecs[3].data = 18'b010_101_110_001_100_111;  // saturation: 80 points of (7,7)
    vecs[3].npts = 80; vecs[3].busy_len = 80; vecs[3].fall_po = 1'b0;
    vecs[3].fx = 3'd0; vecs[3].fy = 3'd0;
    vecs[3].px = {8{3'd7}}; vecs[3].py = {8{3'd7}};

    vecs[4].data = 18'b001_010_011_100_101_110;
    vecs[4].npts = 8; vecs[4].busy_len = 10; vecs[4].fall_po = 1'b1;
    vecs[4].fx = 3'd4; vecs[4].fy = 3'd3;
    vecs[4].px = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    vecs[4].py = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    reset          = 1'b1;
    u_if.tri_valid = 1'b1;  // must be ignored during reset
    u_if.tri_data  = 18'h2AAAA;
    busy = 1'b0; po = 1'b1; xo = 3'd5; yo = 3'd5;
    step();
    @(negedge clk);
    chk("rst_ready", u_if.tri_ready, 1);
    chk("rst_nt", nt, 0);
    chk("rst_done", done, 0);
    step();
    u_if.tri_valid = 1'b0;
    po = 1'b0;
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_ready", u_if.tri_ready, 1);
    chk("post_rst_nt", nt, 0);
    chk("post_rst_xi", xi, 0);
    chk("post_rst_yi", yi, 0);
    chk("post_rst_count", pt_count, 0);
    chk("post_rst_xsum", pt_xsum, 0);
    chk("post_rst_ysum", pt_ysum, 0);
    chk("post_rst_err", err, 0);

    for (int i = 0; i < 5; i++) begin
      run_tri(vecs[i], 1'b0);
    end

    // Points in IDLE are ignored and held results stay put.
    held = int'(pt_count);
    po = 1'b1; xo = 3'd5; yo = 3'd5;
    step(); step(); step();
    po = 1'b0;
    @(negedge clk);
    chk("idle_po_count", pt_count, held);
    run_tri(vecs[0], 1'b0);

    // Valid held high across back-to-back transactions.
    run_tri(vecs[2], 1'b1);
    run_tri(vecs[1], 1'b1);
    run_tri(vecs[4], 1'b0);
    step();
    @(negedge clk);
    chk("after_hold_ready", u_if.tri_ready, 1);

    // Reset in COLLECT after three points abandons the triangle.
    held = n_done;
    u_if.tri_valid = 1'b1;
    u_if.tri_data  = vecs[4].data;
    step();
    u_if.tri_valid = 1'b0;
    step(); step(); step();
    busy = 1'b1; po = 1'b1; xo = 3'd3; yo = 3'd2;
    step(); step(); step();
    po = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy  = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", u_if.tri_ready, 1);
    chk("mid_rst_nt", nt, 0);
    chk("mid_rst_count", pt_count, 0);
    chk("mid_rst_xsum", pt_xsum, 0);
    chk("mid_rst_ysum", pt_ysum, 0);
    chk("mid_rst_err", err, 0);
    repeat (5) step();
    chk("mid_rst_no_done", n_done, held);
    run_tri(vecs[1], 1'b0);

    // Engine that never goes busy.
    u_if.tri_valid = 1'b1;
    u_if.tri_data  = vecs[0].data;
`ifdef TRI_FEEDER_WATCHDOG_EN
    begin
      exp_t e;
      e.c = 0; e.x = 0; e.y = 0; e.e = 1;
      exp_q.push_back(e);
      n_pushed++;
    end
`endif
    step();
    u_if.tri_valid = 1'b0;
    step(); step(); step();
`ifdef TRI_FEEDER_WATCHDOG_EN
    cyc = 0;
    got = 0;
    while (got == 0 && cyc < 300) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        cyc++;
        step();
      end
    end
    chk("wd_done_seen", got, 1);
    chk("wd_done_window", (cyc >= 254 && cyc <= 257), 1);
    step();
    @(negedge clk);
    chk("wd_err_held", err, 1);
    chk("wd_ready", u_if.tri_ready, 1);
`else
    dc = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) dc++;
      step();
    end
    chk("nowd_done", dc, 0);
    chk("nowd_err", err, 0);
    chk("nowd_stuck", u_if.tri_ready, 0);
    do_reset();
`endif

    step();
    chk("sb_empty", exp_q.size(), 0);
    chk("sb_done_total", n_done, n_pushed);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
